uart_rx: RTL



---
 rtl/uart_rx.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronised rxd, centre-sampled 8N1 frames, one-cycle rx_ready/frame_err strobes.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits and a parity_err strobe.
module uart_rx #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned BIT_MAX   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rxd,
  output logic               rx_ready,
  output logic [BIT_MAX-1:0] rx_data,
  output logic               frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic               parity_err
`endif
);

  localparam int unsigned CPB   = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF  = CPB / 2;
  localparam int unsigned CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int unsigned IDX_W = $clog2(BIT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BIT_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;
  logic [BIT_MAX-1:0] sr;
  logic               rxd_meta;
  logic               rxd_s;
`ifdef UART_RX_PARITY_EN
  logic               par_bit;
`endif

  // Two-stage synchroniser; resets to the idle (high) line level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  // Frame FSM; strobes default low every cycle so they last exactly one clock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      sr        <= '0;
      rx_data   <= '0;
      rx_ready  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_ready  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rxd_s) state <= S_START;
        end
        S_START: begin
          if (cnt == CNT_MID) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rxd_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            sr  <= {rxd_s, sr[BIT_MAX-1:1]};
            idx <= idx + IDX_W'(1);
            if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            par_bit <= rxd_s;
            state   <= S_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
`ifdef UART_RX_PARITY_EN
            parity_err <= ^{sr, par_bit};
            if (rxd_s && !(^{sr, par_bit})) begin
`else
            if (rxd_s) begin
`endif
              rx_data  <= sr;
              rx_ready <= 1'b1;
            end
            if (rxd_s) begin
              state <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_BREAK: begin
          cnt <= '0;
          if (rxd_s) state <= S_IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
